// File: rtl/svm_feature_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : svm_feature_loader_if                                         |
// | Brief    : Pixel-stream valid/ready bus feeding svm_feature_loader.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface svm_feature_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic       s_sof;
  logic [7:0] s_pixel;

  modport master (output s_valid, output s_sof, output s_pixel, input s_ready);
  modport slave  (input s_valid, input s_sof, input s_pixel, output s_ready);
endinterface
`default_nettype wire

// File: rtl/svm_feature_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : svm_feature_loader                                            |
// | Brief    : Packs a pixel stream into N signed 16-bit features and holds  |
// |            the vector until acked. Optional macro FEAT_SAT_EN saturates  |
// |            features instead of wrapping.                                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module svm_feature_loader #(
  parameter int N        = 8100,
  parameter int PIX_MEAN = 128,
  parameter int SHIFT    = 2
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  svm_feature_loader_if.slave       s,
  output logic [N*16-1:0]           features_flat,
  output logic                      feat_valid,
  input  wire logic                 feat_ack,
  output logic                      frame_err,
  input  wire logic                 err_clr
);

  localparam int                      c_IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_IDX_W-1:0]      c_LAST_IDX = c_IDX_W'(N - 1);
  localparam logic signed [17:0]      c_MEAN     = 18'(PIX_MEAN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_IDX_W-1:0]   w_idx_nxt;
  logic [c_IDX_W-1:0]   w_wr_idx;
  logic                 w_wr_en;
  logic                 w_err_set;
  logic                 w_accept;
  logic                 r_frame_err;
  logic [15:0]          r_feat [N];

  logic signed [17:0]   w_diff;
  logic [15:0]          w_feat;

  // Pixel is zero-extended so the subtraction is signed over the full 0..255 range.
  assign w_diff = $signed({10'd0, s.s_pixel}) - c_MEAN;

`ifdef FEAT_SAT_EN
  logic signed [17:0]   w_wide;
  assign w_wide = w_diff <<< SHIFT;

  always_comb begin
    w_feat = w_wide[15:0];
    if (w_wide > 18'sd32767) begin
      w_feat = 16'h7FFF;
    end else if (w_wide < -18'sd32768) begin
      w_feat = 16'h8000;
    end
  end
`else
  assign w_feat = 16'(w_diff <<< SHIFT);
`endif

  assign s.s_ready  = (r_state != ST_HOLD);
  assign feat_valid = (r_state == ST_HOLD);
  assign frame_err  = r_frame_err;
  assign w_accept   = s.s_valid && s.s_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr_idx    = r_idx;
    w_wr_en     = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Beats before a start-of-frame are consumed and discarded.
        if (w_accept && s.s_sof) begin
          w_wr_en  = 1'b1;
          w_wr_idx = '0;
          if (N == 1) begin
            w_state_nxt = ST_HOLD;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = ST_FILL;
            w_idx_nxt   = c_IDX_W'(1);
          end
        end
      end
      ST_FILL: begin
        if (w_accept) begin
          w_wr_en = 1'b1;
          if (s.s_sof) begin
            w_err_set = 1'b1;
            w_wr_idx  = '0;
            w_idx_nxt = c_IDX_W'(1);
          end else if (r_idx == c_LAST_IDX) begin
            w_state_nxt = ST_HOLD;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (feat_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        r_feat[k] <= '0;
      end
    end else if (w_wr_en) begin
      r_feat[w_wr_idx] <= w_feat;
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else if (w_err_set) begin
      r_frame_err <= 1'b1;
    end else if (err_clr) begin
      r_frame_err <= 1'b0;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_flat
    assign features_flat[k*16 +: 16] = r_feat[k];
  end

endmodule
`default_nettype wire
